controller_responder: RTL and testbench
=======================================

# controller_responder

Serial responder for the controller port: the device side of the latch/pulse/data protocol that the console-side shift logic samples. It takes eight active-high button levels, snapshots them on a latch from the host, and shifts them out one bit per host pulse on an active-low data line. It sits between the button sources (board switches or a remote input path) and the controller connector pins. Build it in place of a physical pad, or use it to loop back and exercise the receiver.

## Interface
- `SYNC_STAGES`, default 2: flop stages on `latch_in` and `pulse_in`. Minimum 2.
- `DEBOUNCE_CYCLES`, default 16: stable-cycle count for button filtering. Only used with `CONTROLLER_DEBOUNCE_EN`.
- `clk` in 1: the single clock.
- `Reset` in 1: asynchronous, active-high reset.
- `latch_in` in 1: host latch, asynchronous to `clk`, active-high.
- `pulse_in` in 1: host shift clock, asynchronous. Rising edge advances one bit.
- `A, B, Select, Start, U, D, L, R` in 1 each: button levels, 1 = pressed.
- `data_out` out 1: serial data, active-low (0 = pressed).
- `bit_index` out 4: number of bits already shifted in the current frame, 0..8.
- `frame_done` out 1: one-cycle pulse when the 8th bit has been shifted past.

## Operation
- `latch_in` and `pulse_in` each pass through a `SYNC_STAGES`-deep synchronizer, followed by one registered edge detector (rise and fall).
- Shift register `sr[7:0]` bit order, LSB first: A, B, Select, Start, U, D, L, R. `data_out` = ~`sr[0]`, registered.
- States:
  - IDLE: after reset. `sr` = 0, so `data_out` = 1. Pulses are ignored.
  - LATCHED: entered while the synchronized latch is high.
    - `sr` reloads from the buttons every cycle.
    - `bit_index` = 0. Pulses are ignored.
    - On the latch falling edge, the last loaded value is held and the state moves to SHIFT.
  - SHIFT: on each synchronized pulse rising edge:
    - `sr` <= {1'b1, `sr[7:1]`}.
    - `bit_index` increments.
    - When `bit_index` reaches 8, go to DONE and assert `frame_done` in the same cycle as the transition.
  - DONE: `sr` = 8'hFF, so `data_out` = 0, which reads as all-ones at the host. `bit_index` holds at 8. Further pulses are ignored with no wrap-around.
- A latch rising edge in any state goes to LATCHED, aborting any partial frame. Latch has priority over a pulse edge detected in the same cycle.
- Button changes after the latch falls do not affect the frame in flight.
- Reset mid-frame returns to IDLE immediately and asynchronously.

## Timing
- Reset values:
  - `data_out` = 1
  - `bit_index` = 0
  - `frame_done` = 0
  - state IDLE, `sr` = 0, synchronizers = 0, debounce state = 0.
- Latency from an external edge to the state/`sr` update: `SYNC_STAGES` + 1 cycles.
- Latency from that edge to `data_out`: `SYNC_STAGES` + 2 cycles.
- The host must hold each latch and pulse level for at least `SYNC_STAGES` + 2 cycles. Shorter levels may be missed; that is undefined but must not hang the FSM.
- First bit (A) is valid on `data_out` at the latch fall + `SYNC_STAGES` + 2 cycles, at the latest.

## Configuration
- `CONTROLLER_DEBOUNCE_EN` defined:
  - Each button passes through a synchronizer and a counter filter.
  - The filtered level changes only after the raw level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - LATCHED loads the filtered levels.
- `CONTROLLER_DEBOUNCE_EN` undefined:
  - Buttons go through a 2-flop synchronizer only, with no counter logic.
  - `DEBOUNCE_CYCLES` is unused.

## Test plan
- Reset: assert `Reset` mid-SHIFT -> `data_out`=1, `bit_index`=0, `frame_done`=0 immediately; pulses after release are ignored.
- Full frame: buttons A=1, Start=1, R=1, others 0; latch high 8 cycles then low; 8 pulses of 6 cycles high / 6 low -> sampled `data_out` sequence 0,1,1,0,1,1,1,0; `frame_done` pulses once, right after the 8th rising edge.
- Overrun: 4 extra pulses after the frame -> `data_out`=0, `bit_index`=8, no further `frame_done`.
- Abort: latch after 3 pulses, buttons now B=1 only -> `bit_index`=0, then the frame reads 1,0,1,1,1,1,1,1.
- Snapshot hold: change all buttons to 1 after the latch falls -> the frame still carries the values present at the latch fall.
- Debounce (macro on, `DEBOUNCE_CYCLES`=16): A toggles for 10 cycles then latch -> A reads released; A held 20 cycles then latch -> A reads pressed (`data_out`=0 first bit).

Source files
------------

// File: rtl/controller_responder_if.sv
// Host-side bundle of the controller port: latch and pulse from the console,
// serial data and frame status back from the responder.
interface controller_responder_if;
  logic       latch_in;
  logic       pulse_in;
  logic       data_out;
  logic [3:0] bit_index;
  logic       frame_done;

  // Console / shift-logic side
  modport master (
    output latch_in,
    output pulse_in,
    input  data_out,
    input  bit_index,
    input  frame_done
  );

  // Device (responder) side
  modport slave (
    input  latch_in,
    input  pulse_in,
    output data_out,
    output bit_index,
    output frame_done
  );
endinterface

// File: rtl/controller_responder.sv
// Device side of the controller latch/pulse/data protocol. Eight active-high
// button levels are snapshotted while the host latch is high and shifted out
// LSB first (A, B, Select, Start, U, D, L, R) on an active-low data line, one
// bit per synchronized pulse rising edge.
// Optional button filtering is enabled by defining CONTROLLER_DEBOUNCE_EN;
// without it the buttons only pass through a 2-flop synchronizer.
module controller_responder #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   Reset,
  controller_responder_if.slave  bus,
  input  logic                   A,
  input  logic                   B,
  input  logic                   Select,
  input  logic                   Start,
  input  logic                   U,
  input  logic                   D,
  input  logic                   L,
  input  logic                   R
);

  // Elaboration-time parameter sanity checks
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("controller_responder: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
    $error("controller_responder: DEBOUNCE_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCHED = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Raw button vector in shift order, A in bit 0
  logic [7:0] w_buttons_raw;
  logic [7:0] w_buttons;
  assign w_buttons_raw = {R, L, D, U, Start, Select, B, A};

  // ---------------------------------------------------------------------
  // Host control synchronizers and edge detectors
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_latch_sync;
  logic [SYNC_STAGES-1:0] r_pulse_sync;
  logic                   r_latch_prev;
  logic                   r_pulse_prev;
  logic                   w_latch_s;
  logic                   w_pulse_s;
  logic                   w_latch_rise;
  logic                   w_latch_fall;
  logic                   w_pulse_rise;

  // Shift the asynchronous latch/pulse levels through their synchronizer chains
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_latch_sync <= '0;
      r_pulse_sync <= '0;
    end else begin
      r_latch_sync <= {r_latch_sync[SYNC_STAGES-2:0], bus.latch_in};
      r_pulse_sync <= {r_pulse_sync[SYNC_STAGES-2:0], bus.pulse_in};
    end
  end

  // Remember last synchronized levels so edges are seen the cycle they arrive
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_latch_prev <= 1'b0;
      r_pulse_prev <= 1'b0;
    end else begin
      r_latch_prev <= w_latch_s;
      r_pulse_prev <= w_pulse_s;
    end
  end

  assign w_latch_s    = r_latch_sync[SYNC_STAGES-1];
  assign w_pulse_s    = r_pulse_sync[SYNC_STAGES-1];
  assign w_latch_rise = w_latch_s & ~r_latch_prev;
  assign w_latch_fall = ~w_latch_s & r_latch_prev;
  assign w_pulse_rise = w_pulse_s & ~r_pulse_prev;

  // ---------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------
  logic [7:0] r_btn_meta;
  logic [7:0] r_btn_sync;

  // Two-flop synchronizer on every button level
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_btn_meta <= '0;
      r_btn_sync <= '0;
    end else begin
      r_btn_meta <= w_buttons_raw;
      r_btn_sync <= r_btn_meta;
    end
  end

`ifdef CONTROLLER_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_debounce
      logic [CNT_W-1:0] r_cnt;
      logic             r_filt;

      // Accept a new level only after it has differed for DEBOUNCE_CYCLES in a row
      always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (r_btn_sync[gi] == r_filt) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          r_cnt  <= '0;
          r_filt <= r_btn_sync[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_buttons[gi] = r_filt;
    end
  endgenerate
`else
  assign w_buttons = r_btn_sync;
`endif

  // ---------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------
  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_sr;
  logic [7:0] w_sr_next;
  logic [3:0] r_bit_index;
  logic [3:0] w_bit_index_next;
  logic       r_frame_done;
  logic       w_frame_done_next;
  logic       r_data_out;

  // State, shift register and registered outputs
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= IDLE;
      r_sr         <= 8'h00;
      r_bit_index  <= 4'd0;
      r_frame_done <= 1'b0;
      r_data_out   <= 1'b1;
    end else begin
      r_state      <= w_state_next;
      r_sr         <= w_sr_next;
      r_bit_index  <= w_bit_index_next;
      r_frame_done <= w_frame_done_next;
      r_data_out   <= ~r_sr[0];
    end
  end

  // Next-state logic; a latch rising edge overrides everything, including a
  // pulse edge seen in the same cycle
  always_comb begin
    w_state_next      = r_state;
    w_sr_next         = r_sr;
    w_bit_index_next  = r_bit_index;
    w_frame_done_next = 1'b0;

    if (w_latch_rise) begin
      w_state_next     = LATCHED;
      w_sr_next        = w_buttons;
      w_bit_index_next = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          w_sr_next        = 8'h00;
          w_bit_index_next = 4'd0;
        end
        LATCHED: begin
          w_bit_index_next = 4'd0;
          // On the falling edge keep what was loaded last cycle
          if (w_latch_fall) begin
            w_state_next = SHIFT;
          end else begin
            w_sr_next = w_buttons;
          end
        end
        SHIFT: begin
          if (w_pulse_rise) begin
            w_sr_next        = {1'b1, r_sr[7:1]};
            w_bit_index_next = r_bit_index + 4'd1;
            if (r_bit_index == 4'd7) begin
              w_state_next      = DONE;
              w_frame_done_next = 1'b1;
            end
          end
        end
        DONE: begin
          w_sr_next        = 8'hFF;
          w_bit_index_next = 4'd8;
        end
        default: begin
          w_state_next     = IDLE;
          w_sr_next        = 8'h00;
          w_bit_index_next = 4'd0;
        end
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.bit_index  = r_bit_index;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_controller_responder.sv
// Self-checking bench for controller_responder: table-driven frames, hand
// sequences for reset / overrun / abort / snapshot, and randomized frames
// checked against a host-view model of the protocol.
module tb_controller_responder;

  logic       clk;
  logic       rst;
  logic [7:0] btn;   // {R, L, D, U, Start, Select, B, A}

  int n_cmp;
  int n_err;
  int fd_cnt;

  controller_responder_if bus ();

  controller_responder #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus),
    .A     (btn[0]),
    .B     (btn[1]),
    .Select(btn[2]),
    .Start (btn[3]),
    .U     (btn[4]),
    .D     (btn[5]),
    .L     (btn[6]),
    .R     (btn[7])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles during which frame_done is high
  always @(negedge clk) begin
    if (bus.frame_done === 1'b1) fd_cnt++;
  end

  typedef struct {
    logic [7:0] buttons;
    logic [7:0] exp_seq;   // bit i = data_out sampled before pulse i
  } vec_t;

  vec_t vecs[4];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Host latch: level held long enough to be seen, then released
  task automatic do_latch(input logic [7:0] b);
    btn = b;
    bus.latch_in = 1'b1;
    cyc(8);
    bus.latch_in = 1'b0;
    cyc(6);
  endtask

  // Sample data_out, then issue one pulse (6 high / 6 low)
  task automatic pulse_sample(output logic bit_val);
    bit_val = bus.data_out;
    bus.pulse_in = 1'b1;
    cyc(6);
    bus.pulse_in = 1'b0;
    cyc(6);
  endtask

  task automatic read_bits(input int n, output logic [7:0] seq);
    logic b;
    seq = 8'h00;
    for (int i = 0; i < n; i++) begin
      pulse_sample(b);
      seq[i] = b;
    end
  endtask

  // Host-view model: what the console reads on pull k after latching b.
  // Pressed buttons read low; past the eighth pull the line reads low.
  function automatic logic model_read(input logic [7:0] b, input int k);
    if (k >= 8) return 1'b0;
    return b[k] ? 1'b0 : 1'b1;
  endfunction

  function automatic logic [3:0] model_index(input int pulses);
    return (pulses > 8) ? 4'd8 : 4'(pulses);
  endfunction

  initial begin
    logic [7:0] seq;
    logic [7:0] seq2;
    logic       bv;
    int         fd_base;

    n_cmp = 0;
    n_err = 0;
    fd_cnt = 0;
    btn = 8'h00;
    bus.latch_in = 1'b0;
    bus.pulse_in = 1'b0;
    rst = 1'b1;

    vecs[0] = '{buttons: 8'h89, exp_seq: 8'h76};  // A, Start, R -> 0,1,1,0,1,1,1,0
    vecs[1] = '{buttons: 8'h00, exp_seq: 8'hFF};
    vecs[2] = '{buttons: 8'hFF, exp_seq: 8'h00};
    vecs[3] = '{buttons: 8'h02, exp_seq: 8'hFD};

    // Reset state
    cyc(3);
    check("reset_data_out", {7'd0, bus.data_out}, 8'h01);
    check("reset_bit_index", {4'd0, bus.bit_index}, 8'h00);
    check("reset_frame_done", {7'd0, bus.frame_done}, 8'h00);
    rst = 1'b0;
    cyc(2);

    // Pulses in IDLE are ignored
    read_bits(2, seq);
    check("idle_pulse_data", seq, 8'h03);
    check("idle_pulse_index", {4'd0, bus.bit_index}, 8'h00);

    // Table-driven full frames, including frame_done timing and overrun
    for (int v = 0; v < 4; v++) begin
      fd_base = fd_cnt;
      do_latch(vecs[v].buttons);
      read_bits(7, seq);
      check("fd_early", 8'(fd_cnt - fd_base), 8'h00);
      read_bits(1, seq2);
      seq[7] = seq2[0];
      check("table_frame", seq, vecs[v].exp_seq);
      check("table_fd_once", 8'(fd_cnt - fd_base), 8'h01);
      check("table_index8", {4'd0, bus.bit_index}, 8'h08);
      $display("table frame %0d: buttons=%h seq=%h expected=%h", v, vecs[v].buttons, seq, vecs[v].exp_seq);
    end

    // Overrun: four extra pulses after the frame
    fd_base = fd_cnt;
    read_bits(4, seq);
    check("overrun_data", seq, 8'h00);
    check("overrun_data_now", {7'd0, bus.data_out}, 8'h00);
    check("overrun_index", {4'd0, bus.bit_index}, 8'h08);
    check("overrun_no_fd", 8'(fd_cnt - fd_base), 8'h00);
    $display("overrun: 4 extra pulses, seq=%h index=%0d", seq, bus.bit_index);

    // Reset mid-frame acts immediately, pulses afterwards ignored
    do_latch(8'h89);
    read_bits(3, seq);
    rst = 1'b1;
    #1;
    check("midreset_data_out", {7'd0, bus.data_out}, 8'h01);
    check("midreset_index", {4'd0, bus.bit_index}, 8'h00);
    check("midreset_fd", {7'd0, bus.frame_done}, 8'h00);
    cyc(2);
    rst = 1'b0;
    cyc(2);
    read_bits(3, seq);
    check("postreset_data", seq, 8'h07);
    check("postreset_index", {4'd0, bus.bit_index}, 8'h00);
    $display("mid-frame reset: data_out=%b index=%0d", bus.data_out, bus.bit_index);

    // Abort: new latch after three pulses
    do_latch(8'h89);
    read_bits(3, seq);
    btn = 8'h02;
    bus.latch_in = 1'b1;
    cyc(6);
    check("abort_index0", {4'd0, bus.bit_index}, 8'h00);
    cyc(2);
    bus.latch_in = 1'b0;
    cyc(6);
    read_bits(8, seq);
    check("abort_frame", seq, 8'hFD);
    $display("abort frame: seq=%h", seq);

    // Snapshot hold: buttons change after the latch falls
    do_latch(8'h5A);
    btn = 8'hFF;
    read_bits(8, seq);
    check("snapshot_frame", seq, 8'hA5);
    $display("snapshot frame: seq=%h", seq);

    // Randomized frames against the host-view model
    for (int t = 0; t < 10; t++) begin
      logic [7:0] b;
      int         np;
      int         bad;
      b = 8'($urandom);
      np = $urandom_range(0, 11);
      bad = 0;
      fd_base = fd_cnt;
      do_latch(b);
      for (int k = 0; k < np; k++) begin
        pulse_sample(bv);
        n_cmp++;
        if (bv !== model_read(b, k)) begin
          n_err++;
          bad++;
          $display("FAIL rand_bit: frame %0d pull %0d got %b, expected %b", t, k, bv, model_read(b, k));
        end
      end
      check("rand_index", {4'd0, bus.bit_index}, {4'd0, model_index(np)});
      check("rand_data_now", {7'd0, bus.data_out}, {7'd0, model_read(b, np)});
      check("rand_fd", 8'(fd_cnt - fd_base), (np >= 8) ? 8'h01 : 8'h00);
      $display("random frame %0d: buttons=%h pulses=%0d bit errors=%0d", t, b, np, bad);
    end

`ifdef CONTROLLER_DEBOUNCE_EN
    // Debounce: short toggling of A is rejected, a steady press is accepted
    btn = 8'h00;
    cyc(20);
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      cyc(1);
    end
    do_latch(8'h00);
    read_bits(1, seq);
    check("debounce_toggle", seq, 8'h01);
    btn = 8'h01;
    cyc(20);
    do_latch(8'h01);
    read_bits(1, seq);
    check("debounce_held", seq, 8'h00);
    $display("debounce: toggle/held checks done");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
